result_buffer: RTL and testbench
================================

RESULT_BUFFER -- requirements
Module: result_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data width of logic-unit results.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of entries, power of two, at least 2.
REQ-003 SHALL have port Clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit, meaning reset, synchronous and active-high.
REQ-005 SHALL have port Flush, input, 1 bit, meaning synchronous discard of all buffered entries.
REQ-006 SHALL have port In_Data, input, WIDTH, meaning result word from the upstream bitwise logic stage.
REQ-007 SHALL have port In_Valid, input, 1 bit, meaning In_Data is valid this cycle.
REQ-008 SHALL have port In_Ready, output, 1 bit, meaning the buffer accepts a word this cycle.
REQ-009 SHALL have port Out_Data, output, WIDTH, meaning head-of-buffer word.
REQ-010 SHALL have port Out_Zero, output, 1 bit, meaning Out_Data equals zero, as stored with the entry.
REQ-011 SHALL have port Out_Valid, output, 1 bit, meaning Out_Data/Out_Zero are valid.
REQ-012 SHALL have port Out_Ready, input, 1 bit, meaning the consumer takes the head word this cycle.
REQ-013 SHALL have port Count, output, clog2(DEPTH+1) bits, meaning current occupancy.
REQ-014 SHALL have port Overrun, output, 1 bit, meaning sticky flag: In_Valid was high while full.

Function
REQ-015 Push SHALL occur when In_Valid and In_Ready are both high at a rising edge.
REQ-016 Pop SHALL occur when Out_Valid and Out_Ready are both high at a rising edge.
REQ-017 In_Ready SHALL equal (Count != DEPTH), derived from registered state only, with no combinational path from Out_Ready.
REQ-018 Out_Valid SHALL equal (Count != 0).
REQ-019 Out_Data and Out_Zero SHALL be driven from the storage entry at the read pointer (show-ahead).
REQ-020 The zero bit SHALL be computed as (In_Data == 0) at push time and stored alongside the word.
REQ-021 Latency: a word pushed at edge N SHALL appear on Out_Data with Out_Valid high after edge N, i.e. one cycle; there SHALL be no same-cycle pass-through.
REQ-022 Read and write pointers SHALL each advance by 1 per pop/push and wrap from DEPTH-1 to 0.
REQ-023 Count SHALL be incremented on push-only, decremented on pop-only, and held on simultaneous push and pop or on no operation.
REQ-024 Full: no push occurs because In_Ready is low; a simultaneous pop still occurs, and In_Ready rises the next cycle.
REQ-025 Empty: no pop occurs; a simultaneous push is accepted, and Out_Valid rises the next cycle.
REQ-026 Overrun SHALL set on any edge where In_Valid is high and Count == DEPTH, and SHALL clear only on Reset or Flush.
REQ-027 Flush SHALL zero both pointers, Count, and Overrun at the edge; any push or pop in the same cycle SHALL be discarded.
REQ-028 Storage contents SHALL NOT be cleared by Flush or Reset; outputs are masked by Out_Valid.

Reset
REQ-029 Reset SHALL have priority over Flush and all handshakes.
REQ-030 After a Reset edge: Count=0, Out_Valid=0, In_Ready=1, Overrun=0, pointers=0; Out_Data/Out_Zero are don't-care while Out_Valid=0.
REQ-031 Reset asserted mid-stream SHALL discard all buffered entries, and the in-flight push/pop SHALL have no effect.

Structure
REQ-032 WIDTH and DEPTH defaults SHALL live in the shared DSP constants package/include, alongside the datapath width used by the logic units.
REQ-033 One sub-module, result_buffer_mem (DEPTH x (WIDTH+1) register array, one write port, asynchronous read), SHALL hold storage; pointer, count, and flag logic stay in result_buffer.

Verification
REQ-034 Reset, then push 0x3C -> next cycle Out_Valid=1, Out_Data=0x3C, Out_Zero=0, Count=1.
REQ-035 Push 0xA5, 0x00, 0xFF, 0x5A with Out_Ready=0 -> Count=4, In_Ready=0, Out_Data=0xA5; then pop, and the second word reads 0x00 with Out_Zero=1.
REQ-036 While full, assert In_Valid=1 and Out_Ready=1 together -> one pop, no push, Count=3, Overrun=1, In_Ready=1 next cycle.
REQ-037 Run continuous push and pop for 10 words 0x01..0x0A starting with Count=1 -> output order is preserved across pointer wrap, and Count stays 1.
REQ-038 Hold Count=3, assert Flush together with a push of 0x77 -> next cycle Count=0, Out_Valid=0, Overrun=0, and 0x77 never appears.
REQ-039 Assert Reset in the same cycle as a push and a Flush -> post-reset state matches REQ-030.

Source files
------------

// File: rtl/result_buffer_pkg.sv
// Shared DSP constants for the logic-unit datapath and its result buffer.
package result_buffer_pkg;

    localparam int DSP_DATA_WIDTH       = 8;
    localparam int RESULT_BUFFER_WIDTH  = DSP_DATA_WIDTH;
    localparam int RESULT_BUFFER_DEPTH  = 4;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } buffer_op_t;

endpackage

// File: rtl/result_buffer_mem.sv
// Storage array for the result buffer: one synchronous write port, asynchronous read.
module result_buffer_mem
    import result_buffer_pkg::*;
#(
    parameter int WIDTH = RESULT_BUFFER_WIDTH,
    parameter int DEPTH = RESULT_BUFFER_DEPTH,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [WIDTH:0] wdata,
    input  logic [PW-1:0] raddr,
    output logic [WIDTH:0] rdata
);

    // Entries are never cleared; the consumer side masks them with the valid flag.
    logic [WIDTH:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/result_buffer.sv
// Show-ahead result FIFO behind the bitwise logic stage, storing a zero flag per word.
module result_buffer
    import result_buffer_pkg::*;
#(
    parameter int WIDTH = RESULT_BUFFER_WIDTH,
    parameter int DEPTH = RESULT_BUFFER_DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Flush,
    input  logic [WIDTH-1:0] In_Data,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [WIDTH-1:0] Out_Data,
    output logic             Out_Zero,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [CW-1:0]    Count,
    output logic             Overrun
);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overrun;
    logic          full;
    logic          push;
    logic          pop;
    logic          write_en;
    buffer_op_t    op;
    logic [WIDTH:0] head;

    // Handshake readiness depends only on registered occupancy.
    assign full      = (count == CW'(DEPTH));
    assign In_Ready  = !full;
    assign Out_Valid = (count != '0);
    assign push      = In_Valid && !full;
    assign pop       = Out_Valid && Out_Ready;
    assign op        = buffer_op_t'({pop, push});
    assign write_en  = push && !Reset && !Flush;

    always_ff @(posedge Clk) begin
        if (Reset || Flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case (op)
                OP_PUSH: count <= count + CW'(1);
                OP_POP:  count <= count - CW'(1);
                default: count <= count;
            endcase
            if (In_Valid && full) begin
                overrun <= 1'b1;
            end
        end
    end

    result_buffer_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (Clk),
        .we    (write_en),
        .waddr (wr_ptr),
        .wdata ({(In_Data == '0), In_Data}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign Out_Data = head[WIDTH-1:0];
    assign Out_Zero = head[WIDTH];
    assign Count    = count;
    assign Overrun  = overrun;

endmodule

// File: tb/tb_result_buffer.sv
// Self-checking bench for result_buffer: directed vector table, wrap sequence, random run vs queue model.
module tb_result_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Flush = 1'b0;
    logic [WIDTH-1:0] In_Data = '0;
    logic             In_Valid = 1'b0;
    logic             In_Ready;
    logic [WIDTH-1:0] Out_Data;
    logic             Out_Zero;
    logic             Out_Valid;
    logic             Out_Ready = 1'b0;
    logic [CW-1:0]    Count;
    logic             Overrun;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of {zero, data} plus the sticky flag.
    logic [WIDTH:0] model_q[$];
    bit             model_ovr = 1'b0;

    result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Flush     (Flush),
        .In_Data   (In_Data),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Out_Data  (Out_Data),
        .Out_Zero  (Out_Zero),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Count     (Count),
        .Overrun   (Overrun)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       rst;
        logic       flush;
        logic       iv;
        logic [7:0] data;
        logic       ordy;
        int         exp_count;
        logic       exp_ovalid;
        logic       exp_iready;
        logic       exp_ovr;
        logic       chk_data;
        logic [7:0] exp_data;
        logic       exp_zero;
    } vec_t;

    vec_t vecs[$];

    task automatic checkVal(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs, advance the model by the same edge, and settle past the edge.
    task automatic applyStimulus(input logic r, input logic f, input logic iv,
                                 input logic [7:0] d, input logic ordy);
        bit was_full;
        bit do_pop;
        bit do_push;
        Reset     = r;
        Flush     = f;
        In_Valid  = iv;
        In_Data   = d;
        Out_Ready = ordy;
        if (r || f) begin
            model_q.delete();
            model_ovr = 1'b0;
        end else begin
            was_full = (model_q.size() == DEPTH);
            if (iv && was_full) model_ovr = 1'b1;
            do_pop  = ordy && (model_q.size() > 0);
            do_push = iv && !was_full;
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back({(d == 8'h00), d});
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".count"},    int'(Count),     model_q.size());
        checkVal({tag, ".outvalid"}, int'(Out_Valid), int'(model_q.size() != 0));
        checkVal({tag, ".inready"},  int'(In_Ready),  int'(model_q.size() != DEPTH));
        checkVal({tag, ".overrun"},  int'(Overrun),   int'(model_ovr));
        if (model_q.size() != 0) begin
            checkVal({tag, ".data"}, int'(Out_Data), int'(model_q[0][WIDTH-1:0]));
            checkVal({tag, ".zero"}, int'(Out_Zero), int'(model_q[0][WIDTH]));
        end
    endtask

    function automatic vec_t mk(logic r, logic f, logic iv, logic [7:0] d, logic ordy,
                                int c, logic ov, logic ir, logic ovr,
                                logic cd, logic [7:0] ed, logic ez);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.data = d; v.ordy = ordy;
        v.exp_count = c; v.exp_ovalid = ov; v.exp_iready = ir; v.exp_ovr = ovr;
        v.chk_data = cd; v.exp_data = ed; v.exp_zero = ez;
        return v;
    endfunction

    initial begin
        int idx;
        //          r  f  iv data   ordy cnt ov ir ovr cd data  z
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 1, 8'h3C, 0, 1, 1, 1, 0, 1, 8'h3C, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 1, 8'h05, 1, 1, 1, 1, 0, 1, 8'h05, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 1, 8'hA5, 0, 1, 1, 1, 0, 1, 8'hA5, 0));
        vecs.push_back(mk(0, 0, 1, 8'h00, 0, 2, 1, 1, 0, 1, 8'hA5, 0));
        vecs.push_back(mk(0, 0, 1, 8'hFF, 0, 3, 1, 1, 0, 1, 8'hA5, 0));
        vecs.push_back(mk(0, 0, 1, 8'h5A, 0, 4, 1, 0, 0, 1, 8'hA5, 0));
        vecs.push_back(mk(0, 0, 1, 8'h11, 1, 3, 1, 1, 1, 1, 8'h00, 1));
        vecs.push_back(mk(0, 1, 1, 8'h77, 0, 0, 0, 1, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 1, 8'h42, 0, 1, 1, 1, 0, 1, 8'h42, 0));
        vecs.push_back(mk(0, 0, 1, 8'h02, 0, 2, 1, 1, 0, 1, 8'h42, 0));
        vecs.push_back(mk(0, 0, 1, 8'h03, 0, 3, 1, 1, 0, 1, 8'h42, 0));
        vecs.push_back(mk(0, 0, 1, 8'h04, 0, 4, 1, 0, 0, 1, 8'h42, 0));
        vecs.push_back(mk(0, 0, 1, 8'hEE, 0, 4, 1, 0, 1, 1, 8'h42, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 3, 1, 1, 1, 1, 8'h02, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 3, 1, 1, 1, 1, 8'h02, 0));
        vecs.push_back(mk(1, 1, 1, 8'h99, 1, 0, 0, 1, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0));

        idx = 0;
        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", idx);
            applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].data, vecs[i].ordy);
            checkVal({tag, ".count"},    int'(Count),     vecs[i].exp_count);
            checkVal({tag, ".outvalid"}, int'(Out_Valid), int'(vecs[i].exp_ovalid));
            checkVal({tag, ".inready"},  int'(In_Ready),  int'(vecs[i].exp_iready));
            checkVal({tag, ".overrun"},  int'(Overrun),   int'(vecs[i].exp_ovr));
            if (vecs[i].chk_data) begin
                checkVal({tag, ".data"}, int'(Out_Data), int'(vecs[i].exp_data));
                checkVal({tag, ".zero"}, int'(Out_Zero), int'(vecs[i].exp_zero));
            end
            idx++;
        end

        $display("[TB] streaming sequence across pointer wrap");
        applyStimulus(0, 0, 1, 8'h01, 0);
        checkVal("stream.count0", int'(Count), 1);
        checkVal("stream.data0",  int'(Out_Data), 1);
        for (int k = 2; k <= 10; k++) begin
            applyStimulus(0, 0, 1, 8'(k), 1);
            checkVal($sformatf("stream.count%0d", k), int'(Count), 1);
            checkVal($sformatf("stream.data%0d", k),  int'(Out_Data), k);
        end
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkVal("stream.drain", int'(Out_Valid), 0);

        $display("[TB] randomized run against queue model");
        for (int n = 0; n < 600; n++) begin
            logic       r, f, iv, ordy;
            logic [7:0] d;
            r    = ($urandom_range(0, 79) == 0);
            f    = ($urandom_range(0, 39) == 0);
            iv   = ($urandom_range(0, 9) < 6);
            ordy = ($urandom_range(0, 9) < ((n / 100) % 2 == 0 ? 3 : 7));
            d    = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            applyStimulus(r, f, iv, d, ordy);
            checkOutput($sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
